// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and range filter in front of the data memory.
// Define DMEM_CLEAR_EN to build the post-reset zeroing sweep (CLEAR state).
module dmem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_rdata,
    output logic             rsp0_err,
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_rdata,
    output logic             rsp1_err,
    output logic             mem_write_read,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic             init_done
);
    localparam logic [WIDTH:0] DEPTH_W = (WIDTH+1)'(MEM_DEPTH);

    logic             in_idle;
    logic             win0;
    logic             grant0;
    logic             grant1;
    logic             granted;
    logic             rr_last;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             in_range;

`ifdef DMEM_CLEAR_EN
    localparam int CW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] clr_cnt;
    logic [CW-1:0] clr_cnt_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = '0;
        if (state == CLEAR) begin
            clr_cnt_nx = clr_cnt + CW'(1);
            if (clr_cnt == CW'(MEM_DEPTH - 1)) begin
                state_nx   = IDLE;
                clr_cnt_nx = '0;
            end
        end
    end

    assign in_idle = (state == IDLE);
`else
    assign in_idle = 1'b1;
`endif

    assign init_done = in_idle;

    // Port 0 wins when alone, under fixed priority, or when port 1 went last.
    assign win0    = !req1_valid || (FIXED_PRIO != 0) || rr_last;
    assign grant0  = in_idle && req0_valid && win0;
    assign grant1  = in_idle && req1_valid && !grant0;
    assign granted = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    assign in_range  = {1'b0, sel_addr} < DEPTH_W;

    always_comb begin
        mem_write_read = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (granted && in_range) begin
            mem_write_read = sel_we;
            mem_address    = sel_addr;
            mem_write_data = sel_wdata;
        end
`ifdef DMEM_CLEAR_EN
        if (!in_idle) begin
            mem_write_read = 1'b1;
            mem_address    = WIDTH'(clr_cnt);
            mem_write_data = '0;
        end
`endif
    end

    // Reads and rejected writes both answer; good writes stay silent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last    <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (granted) begin
                rr_last <= grant1;
            end
            if (grant0 && (!sel_we || !in_range)) begin
                rsp0_valid <= 1'b1;
                rsp0_rdata <= in_range ? mem_read_data : '0;
                rsp0_err   <= !in_range;
            end
            if (grant1 && (!sel_we || !in_range)) begin
                rsp1_valid <= 1'b1;
                rsp1_rdata <= in_range ? mem_read_data : '0;
                rsp1_err   <= !in_range;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives a round-robin and a fixed-priority arbiter, each with
// its own behavioural memory, and checks them against a reference memory model.
module tb_dmem_arbiter;
    localparam int W = 32;
    localparam int D = 256;
`ifdef DMEM_CLEAR_EN
    localparam logic EXP_DONE = 1'b0;
`else
    localparam logic EXP_DONE = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic         a_v0, a_we0, a_rdy0, a_rv0, a_re0;
    logic [W-1:0] a_ad0, a_wd0, a_rd0;
    logic         a_v1, a_we1, a_rdy1, a_rv1, a_re1;
    logic [W-1:0] a_ad1, a_wd1, a_rd1;
    logic         a_mwr, a_done;
    logic [W-1:0] a_mad, a_mwd, a_mrd;

    logic         b_v0, b_we0, b_rdy0, b_rv0, b_re0;
    logic [W-1:0] b_ad0, b_wd0, b_rd0;
    logic         b_v1, b_we1, b_rdy1, b_rv1, b_re1;
    logic [W-1:0] b_ad1, b_wd1, b_rd1;
    logic         b_mwr, b_done;
    logic [W-1:0] b_mad, b_mwd, b_mrd;

    logic [W-1:0] mem_a [D];
    logic [W-1:0] mem_b [D];
    logic [W-1:0] ref_a [D];
    logic [W-1:0] ref_b [D];

    dmem_arbiter #(.WIDTH(W), .MEM_DEPTH(D), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(a_v0), .req0_we(a_we0), .req0_addr(a_ad0),
        .req0_wdata(a_wd0), .req0_ready(a_rdy0),
        .rsp0_valid(a_rv0), .rsp0_rdata(a_rd0), .rsp0_err(a_re0),
        .req1_valid(a_v1), .req1_we(a_we1), .req1_addr(a_ad1),
        .req1_wdata(a_wd1), .req1_ready(a_rdy1),
        .rsp1_valid(a_rv1), .rsp1_rdata(a_rd1), .rsp1_err(a_re1),
        .mem_write_read(a_mwr), .mem_address(a_mad),
        .mem_write_data(a_mwd), .mem_read_data(a_mrd),
        .init_done(a_done)
    );

    dmem_arbiter #(.WIDTH(W), .MEM_DEPTH(D), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(b_v0), .req0_we(b_we0), .req0_addr(b_ad0),
        .req0_wdata(b_wd0), .req0_ready(b_rdy0),
        .rsp0_valid(b_rv0), .rsp0_rdata(b_rd0), .rsp0_err(b_re0),
        .req1_valid(b_v1), .req1_we(b_we1), .req1_addr(b_ad1),
        .req1_wdata(b_wd1), .req1_ready(b_rdy1),
        .rsp1_valid(b_rv1), .rsp1_rdata(b_rd1), .rsp1_err(b_re1),
        .mem_write_read(b_mwr), .mem_address(b_mad),
        .mem_write_data(b_mwd), .mem_read_data(b_mrd),
        .init_done(b_done)
    );

    function automatic logic [W-1:0] init_word(int i);
`ifdef DMEM_CLEAR_EN
        return '1;
`else
        return 32'h5A00_0000 + W'(i) * 32'h0001_0003;
`endif
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < D; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (a_mwr && a_mad < W'(D)) mem_a[a_mad[7:0]] <= a_mwd;
            if (b_mwr && b_mad < W'(D)) mem_b[b_mad[7:0]] <= b_mwd;
        end
    end

    assign a_mrd = (a_mad < W'(D)) ? mem_a[a_mad[7:0]] : '0;
    assign b_mrd = (b_mad < W'(D)) ? mem_b[b_mad[7:0]] : '0;

    function automatic logic [W-1:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 6) return W'($urandom_range(0, 15));
        if (r < 8) return W'($urandom_range(0, D - 1));
        if (r == 8) return W'(D) + W'($urandom_range(0, 3));
        return $urandom | 32'h8000_0000;
    endfunction

    task automatic clear_inputs();
        a_v0 = 0; a_we0 = 0; a_ad0 = '0; a_wd0 = '0;
        a_v1 = 0; a_we1 = 0; a_ad1 = '0; a_wd1 = '0;
        b_v0 = 0; b_we0 = 0; b_ad0 = '0; b_wd0 = '0;
        b_v1 = 0; b_we1 = 0; b_ad1 = '0; b_wd1 = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
`ifdef DMEM_CLEAR_EN
        for (int i = 0; i < D; i++) begin
            ref_a[i] = '0;
            ref_b[i] = '0;
        end
        for (int i = 0; i < 2 * D && !(a_done && b_done); i++) @(negedge clk);
`endif
        #1;
        n_chk++;
        if ({a_done, b_done} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_wait init_done got %b want 11", {a_done, b_done});
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1 preload = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        n_chk++;
        if ({a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp_a got %h want 0",
                     {a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1});
        end
        n_chk++;
        if ({b_rv0, b_rv1, b_re0, b_re1, b_rd0, b_rd1} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp_b got %h want 0",
                     {b_rv0, b_rv1, b_re0, b_re1, b_rd0, b_rd1});
        end
        n_chk++;
        if ({a_done, b_done} !== {EXP_DONE, EXP_DONE}) begin
            n_fail++;
            $display("FAIL reset_done got %b want %b", {a_done, b_done}, EXP_DONE);
        end
        a_v0 = 1'b1; a_we0 = 1'b0; a_ad0 = 32'h5;
        #1;
        n_chk++;
        if (a_rdy0 !== EXP_DONE) begin
            n_fail++;
            $display("FAIL reset_first_ready got %b want %b", a_rdy0, EXP_DONE);
        end
        @(posedge clk); #1;
        n_chk++;
        if (a_rv0 !== EXP_DONE || (EXP_DONE && a_rd0 !== ref_a[5])) begin
            n_fail++;
            $display("FAIL reset_first_read got %b/%h want %b/%h",
                     a_rv0, a_rd0, EXP_DONE, ref_a[5]);
        end
        clear_inputs();
    endtask

`ifdef DMEM_CLEAR_EN
    task automatic test_clear();
        clear_inputs();
        a_v0 = 1'b1; a_ad0 = 32'h80;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < D; i++) begin
            ref_a[i] = '0;
            ref_b[i] = '0;
        end
        for (int i = 0; i < D; i++) begin
            #1;
            n_chk++;
            if ({a_done, a_rdy0, a_mwr, a_mad, a_mwd} !==
                {1'b0, 1'b0, 1'b1, W'(i), W'(0)}) begin
                n_fail++;
                $display("FAIL clear_sweep[%0d] got %b%b%b %h %h want 001 %h 0",
                         i, a_done, a_rdy0, a_mwr, a_mad, a_mwd, W'(i));
            end
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({a_done, a_rdy0, a_mwr, a_mad} !== {1'b1, 1'b1, 1'b0, 32'h80}) begin
            n_fail++;
            $display("FAIL clear_done got %b%b%b %h want 110 80",
                     a_done, a_rdy0, a_mwr, a_mad);
        end
        @(posedge clk); #1;
        a_v0 = 1'b0;
        n_chk++;
        if ({a_rv0, a_rd0, a_re0} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_read80 got %b %h %b want 1 0 0", a_rv0, a_rd0, a_re0);
        end
    endtask

    task automatic test_sweep_restart();
        clear_inputs();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 100; i++) @(negedge clk);
        #1;
        n_chk++;
        if ({a_mwr, a_mad} !== {1'b1, 32'd100}) begin
            n_fail++;
            $display("FAIL restart_at100 got %b %h want 1 64", a_mwr, a_mad);
        end
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        n_chk++;
        if ({a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1, a_done} !== '0) begin
            n_fail++;
            $display("FAIL restart_outputs got %h want 0",
                     {a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1, a_done});
        end
        for (int i = 0; i < D; i++) begin
            if (i > 0) #1;
            n_chk++;
            if ({a_done, a_mwr, a_mad} !== {1'b0, 1'b1, W'(i)}) begin
                n_fail++;
                $display("FAIL restart_sweep[%0d] got %b%b %h want 01 %h",
                         i, a_done, a_mwr, a_mad, W'(i));
            end
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({a_done, b_done} !== 2'b11) begin
            n_fail++;
            $display("FAIL restart_done got %b want 11", {a_done, b_done});
        end
    endtask
`endif

    task automatic test_fwd();
        @(negedge clk);
        a_v0 = 1; a_we0 = 1; a_ad0 = 32'h10; a_wd0 = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if ({a_rdy0, a_mwr, a_mad, a_mwd} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL fwd_write got %b%b %h %h want 11 10 deadbeef",
                     a_rdy0, a_mwr, a_mad, a_mwd);
        end
        ref_a[16] = 32'hDEAD_BEEF;
        @(negedge clk);
        a_v0 = 0; a_v1 = 1; a_we1 = 0; a_ad1 = 32'h10;
        #1;
        n_chk++;
        if ({a_rdy1, a_rv0} !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_ready1 got rdy1=%b rsp0=%b want 1 0", a_rdy1, a_rv0);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({a_rv1, a_rd1, a_re1} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL fwd_read got %b %h %b want 1 deadbeef 0", a_rv1, a_rd1, a_re1);
        end
        @(negedge clk); a_v1 = 0;
        @(posedge clk); #1;
        n_chk++;
        if (a_rv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_pulse got %b want 0", a_rv1);
        end
    endtask

    task automatic test_oor();
        @(negedge clk);
        a_v1 = 1; a_we1 = 1; a_ad1 = 32'h100; a_wd1 = 32'h1234;
        #1;
        n_chk++;
        if ({a_rdy1, a_mwr, a_mad, a_mwd} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL oor_drive got %b%b %h %h want 10 0 0",
                     a_rdy1, a_mwr, a_mad, a_mwd);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({a_rv1, a_rd1, a_re1} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL oor_rsp got %b %h %b want 1 0 1", a_rv1, a_rd1, a_re1);
        end
        @(negedge clk);
        a_v1 = 0; a_v0 = 1; a_we0 = 0; a_ad0 = 32'h0;
        @(posedge clk); #1;
        n_chk++;
        if ({a_rv0, a_rd0, a_re0} !== {1'b1, ref_a[0], 1'b0}) begin
            n_fail++;
            $display("FAIL oor_addr0 got %b %h %b want 1 %h 0", a_rv0, a_rd0, a_re0, ref_a[0]);
        end
        n_chk++;
        if ({a_rv1, a_re1} !== 2'b01) begin
            n_fail++;
            $display("FAIL oor_hold got %b%b want 01", a_rv1, a_re1);
        end
        @(negedge clk);
        a_ad0 = 32'hFFFF_FF05;
        @(posedge clk); #1;
        n_chk++;
        if ({a_rv0, a_rd0, a_re0} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL oor_highbits got %b %h %b want 1 0 1", a_rv0, a_rd0, a_re0);
        end
        @(negedge clk); a_v0 = 0;
    endtask

    task automatic test_rr_alternate();
        logic g;
        reset_dut();
        n_chk++;
        if ({a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1} !== '0) begin
            n_fail++;
            $display("FAIL rr_reset_rsp got %h want 0",
                     {a_rv0, a_rv1, a_re0, a_re1, a_rd0, a_rd1});
        end
        @(negedge clk);
        a_v0 = 1; a_we0 = 1; a_ad0 = 32'h1; a_wd0 = 32'h1111_1111;
        ref_a[1] = 32'h1111_1111;
        @(negedge clk);
        a_v0 = 0; a_v1 = 1; a_we1 = 1; a_ad1 = 32'h2; a_wd1 = 32'h2222_2222;
        ref_a[2] = 32'h2222_2222;
        @(negedge clk);
        a_v0 = 1; a_we0 = 0; a_we1 = 0;
        for (int k = 0; k < 8; k++) begin
            g = k[0];
            #1;
            n_chk++;
            if ({a_rdy0, a_rdy1, a_mad} !== {!g, g, g ? 32'h2 : 32'h1}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d] got %b%b %h want %b%b",
                         k, a_rdy0, a_rdy1, a_mad, !g, g);
            end
            @(posedge clk); #1;
            n_chk++;
            if ({a_rv0, a_rv1, g ? a_rd1 : a_rd0} !==
                {!g, g, g ? ref_a[2] : ref_a[1]}) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d] got %b%b %h %h", k, a_rv0, a_rv1, a_rd0, a_rd1);
            end
            @(negedge clk);
        end
        a_v0 = 0; a_v1 = 0;
    endtask

    task automatic test_fixed_prio();
        @(negedge clk);
        b_v0 = 1; b_we0 = 1; b_ad0 = 32'h1; b_wd0 = 32'hAAAA_0001;
        ref_b[1] = 32'hAAAA_0001;
        @(negedge clk);
        b_v0 = 0; b_v1 = 1; b_we1 = 1; b_ad1 = 32'h2; b_wd1 = 32'hBBBB_0002;
        ref_b[2] = 32'hBBBB_0002;
        @(negedge clk);
        b_v0 = 1; b_we0 = 0; b_we1 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++;
            if ({b_rdy0, b_rdy1} !== 2'b10) begin
                n_fail++;
                $display("FAIL fp_grant[%0d] got %b%b want 10", k, b_rdy0, b_rdy1);
            end
            @(posedge clk); #1;
            n_chk++;
            if ({b_rv0, b_rv1, b_rd0} !== {1'b1, 1'b0, ref_b[1]}) begin
                n_fail++;
                $display("FAIL fp_rsp[%0d] got %b%b %h want 10 %h",
                         k, b_rv0, b_rv1, b_rd0, ref_b[1]);
            end
            @(negedge clk);
        end
        b_v0 = 0;
        #1;
        n_chk++;
        if ({b_rdy0, b_rdy1} !== 2'b01) begin
            n_fail++;
            $display("FAIL fp_drop got %b%b want 01", b_rdy0, b_rdy1);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({b_rv1, b_rd1, b_re1} !== {1'b1, ref_b[2], 1'b0}) begin
            n_fail++;
            $display("FAIL fp_rsp1 got %b %h %b want 1 %h 0", b_rv1, b_rd1, b_re1, ref_b[2]);
        end
        @(negedge clk); b_v1 = 0;
    endtask

    task automatic test_random();
        logic         g0, g1, gnt, we, in_r, last;
        logic         ev0, ev1, ee, hold0, hold1, em_w;
        logic [W-1:0] ad, wd, ed, em_a, em_d;
        reset_dut();
        last = 1'b1; hold0 = 0; hold1 = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!hold0) begin
                a_v0 = ($urandom_range(0, 3) != 0); a_we0 = 1'($urandom_range(0, 1));
                a_ad0 = rand_addr(); a_wd0 = $urandom;
            end
            if (!hold1) begin
                a_v1 = ($urandom_range(0, 3) != 0); a_we1 = 1'($urandom_range(0, 1));
                a_ad1 = rand_addr(); a_wd1 = $urandom;
            end
            #1;
            g0 = a_v0 && (!a_v1 || last);
            g1 = a_v1 && !g0;
            gnt = g0 || g1;
            n_chk++;
            if ({a_rdy0, a_rdy1} !== {g0, g1}) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d] got %b%b want %b%b", c, a_rdy0, a_rdy1, g0, g1);
            end
            we = g1 ? a_we1 : a_we0;
            ad = g1 ? a_ad1 : a_ad0;
            wd = g1 ? a_wd1 : a_wd0;
            in_r = ad < W'(D);
            em_w = gnt && in_r && we;
            em_a = (gnt && in_r) ? ad : '0;
            em_d = (gnt && in_r) ? wd : '0;
            n_chk++;
            if ({a_mwr, a_mad, a_mwd} !== {em_w, em_a, em_d}) begin
                n_fail++;
                $display("FAIL rnd_mem[%0d] got %b %h %h want %b %h %h",
                         c, a_mwr, a_mad, a_mwd, em_w, em_a, em_d);
            end
            ev0 = g0 && (!we || !in_r);
            ev1 = g1 && (!we || !in_r);
            ed = in_r ? ref_a[ad[7:0]] : '0;
            ee = !in_r;
            if (em_w) ref_a[ad[7:0]] = wd;
            if (gnt) last = g1;
            hold0 = a_v0 && !g0;
            hold1 = a_v1 && !g1;
            @(posedge clk); #1;
            n_chk++;
            if ({a_rv0, a_rv1} !== {ev0, ev1}) begin
                n_fail++;
                $display("FAIL rnd_rspv[%0d] got %b%b want %b%b", c, a_rv0, a_rv1, ev0, ev1);
            end
            if (ev0 || ev1) begin
                n_chk++;
                if ((ev0 ? {a_rd0, a_re0} : {a_rd1, a_re1}) !== {ed, ee}) begin
                    n_fail++;
                    $display("FAIL rnd_rspd[%0d] got %h %b/%h %b want %h %b",
                             c, a_rd0, a_re0, a_rd1, a_re1, ed, ee);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        preload = 1'b1;
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < D; i++) begin
            ref_a[i] = init_word(i);
            ref_b[i] = init_word(i);
        end
        test_reset();
`ifdef DMEM_CLEAR_EN
        test_clear();
        test_sweep_restart();
`endif
        test_fwd();
        test_oor();
        test_rr_alternate();
        test_fixed_prio();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller in front of the single-port, word-addressed data memory (WIDTH-bit words, MEM_DEPTH entries).
- Port 0 is the core load/store unit. Port 1 is the loader/debug/DMA master.
- Grants at most one access per cycle and drives the memory's write_read/address/write_data lines.
- Registers read data into a per-port response, and filters out-of-range addresses.
- Optionally sweeps the memory to zero after reset, since the memory itself has no reset.

Parameters:
- WIDTH, 32, data and address width.
- MEM_DEPTH, 256, number of memory words; valid addresses are 0..MEM_DEPTH-1.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk  in  1  global clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-low reset (sampled on posedge clk).
- req0_valid  in  1  port 0 request.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  WIDTH  port 0 word address.
- req0_wdata  in  WIDTH  port 0 write data.
- req0_ready  out  1  port 0 grant; a transfer occurs when valid&&ready at the clock edge.
- rsp0_valid  out  1  port 0 read response valid, one-cycle pulse.
- rsp0_rdata  out  WIDTH  port 0 read data.
- rsp0_err  out  1  port 0 address out of range; qualified by rsp0_valid.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- mem_write_read  out  1  to memory write_read; 1 = write.
- mem_address  out  WIDTH  to memory address.
- mem_write_data  out  WIDTH  to memory write_data.
- mem_read_data  in  WIDTH  from memory read_data (combinational read).
- init_done  out  1  high when the arbiter is accepting requests.

Behaviour:
- States: CLEAR, IDLE. Reset (reset==0 at posedge) enters CLEAR if DMEM_CLEAR_EN is defined, else IDLE.
- Reset values:
  - all rsp*_valid, rsp*_rdata, rsp*_err = 0.
  - clr_cnt = 0.
  - rr_last = 1, so port 0 wins the first tie.
  - init_done = 0 in CLEAR, 1 in IDLE.
- CLEAR state:
  - req0_ready = req1_ready = 0.
  - mem_write_read = 1, mem_address = clr_cnt, mem_write_data = 0.
  - clr_cnt increments each cycle.
  - When clr_cnt == MEM_DEPTH-1, next state is IDLE and clr_cnt returns to 0. The sweep takes exactly MEM_DEPTH cycles.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- IDLE state, arbitration (combinational, same cycle):
  - Only one valid: that port gets ready=1.
  - Both valid, FIXED_PRIO=1: port 0.
  - Both valid, FIXED_PRIO=0: the port != rr_last.
  - rr_last <= granted port on every grant. It is unchanged when there is no grant.
  - The ungranted port sees ready=0 and must hold its request stable.
- IDLE state, memory drive:
  - Granted port, in-range address (addr < MEM_DEPTH): mem_address = addr, mem_write_data = wdata, mem_write_read = we.
  - Granted port, out-of-range address: mem_write_read forced to 0 (write suppressed). mem_address = 0, mem_write_data = 0. The request is still accepted (ready=1).
  - No grant: mem_write_read = 0, mem_address = 0, mem_write_data = 0.
- Response:
  - A granted read produces rspN_valid = 1 on the following cycle, for exactly one cycle.
  - rspN_rdata = mem_read_data sampled at the grant edge, or 0 if out of range.
  - rspN_err = 1 if out of range.
  - A granted write produces no rsp_valid, except that an out-of-range write pulses rspN_valid with rspN_err = 1 and rdata = 0.
  - Otherwise rsp*_valid = 0; rsp*_rdata and rsp*_err hold their last values.
- Throughput and ordering:
  - One access per cycle; back-to-back grants allowed.
  - Read latency is 1 cycle from grant.
  - A write followed by a read of the same address, on either port, in the next cycle returns the new data.
- Address compare: the full WIDTH-bit address is compared against MEM_DEPTH, unsigned. Upper bits are not truncated.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined: post-reset CLEAR sweep as above; init_done stays low for MEM_DEPTH cycles after reset deasserts.
- Undefined: the CLEAR state and clr_cnt are not built; reset goes directly to IDLE; init_done = 1 from the first cycle after reset.

Test Plan:
- DMEM_CLEAR_EN defined, MEM_DEPTH=256, memory preloaded with 0xFFFF_FFFF, release reset:
  - required: 256 consecutive write cycles, addresses 0..255, data 0.
  - required: init_done rises on cycle 257.
  - required: a port 0 read of address 0x80 returns 0.
- Port 0 write addr 0x10 data 0xDEAD_BEEF, next cycle port 1 read 0x10:
  - required: req1_ready=1.
  - required: one cycle later rsp1_valid=1 with rdata 0xDEAD_BEEF, err=0.
- FIXED_PRIO=0, both ports continuously requesting reads (port 0 addr 1, port 1 addr 2):
  - required: grants alternate 0,1,0,1 starting with port 0.
  - required: each rsp pulse carries its own port's data.
- FIXED_PRIO=1, same stimulus:
  - required: port 0 granted every cycle, port 1 never; when port 0 drops valid, port 1 is granted that same cycle.
- Port 1 write addr 0x100 (≥ MEM_DEPTH) data 0x1234:
  - required: mem_write_read stays 0.
  - required: rsp1_valid=1 with err=1, rdata=0.
  - required: a read of address 0x00 is unchanged.
- reset pulled low at sweep address 100, held 1 cycle:
  - required: all outputs reset, then the sweep restarts at address 0.
  - required: init_done rises after 256 further cycles.
